// File: rtl/ahfp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahfp_pkg
// Purpose  : IEEE-754 single-precision field widths and constants shared by
//            the ahfp arithmetic blocks.
// Revision : 1.0  initial release
// ============================================================================
package ahfp_pkg;

    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int FP32_BIAS  = 127;

    typedef struct packed {
        logic                  sign;
        logic [FP32_EXP_W-1:0] exp;
        logic [FP32_MAN_W-1:0] man;
    } fp32_t;

    localparam fp32_t FP32_POS_ZERO = '0;

endpackage
`default_nettype wire

// File: rtl/ahfp_lzd_n.sv
`default_nettype none
// ============================================================================
// Module   : ahfp_lzd_n
// Purpose  : Combinational leading-one detector of width W; returns the bit
//            index of the most significant set bit and a non-zero flag.
// Revision : 1.0  initial release
// ============================================================================
module ahfp_lzd_n #(
    parameter int W     = 32,
    parameter int IDX_W = $clog2(W)
) (
    input  wire logic [W-1:0]     i_data,
    output logic      [IDX_W-1:0] o_idx,
    output logic                  o_valid
);

    // Ascending scan: the highest set bit is the last one to write the index.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i_data[i]) begin
                o_idx   = IDX_W'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahfp_fixed_2_float_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ahfp_fixed_2_float_pipe
// Purpose  : Three-stage valid/ready pipeline converting signed fixed-point
//            (IN_W bits, FRAC_BITS fractional) to IEEE-754 single precision.
//            Define AHFP_F2F_ROUND_NEAREST_EN for round-to-nearest-even;
//            otherwise results truncate toward zero.
// Revision : 1.0  initial release
// ============================================================================
module ahfp_fixed_2_float_pipe
    import ahfp_pkg::*;
#(
    parameter int IN_W      = 32,
    parameter int FRAC_BITS = 29
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            in_valid,
    output logic                 in_ready,
    input  wire logic [IN_W-1:0] in_data,
    output logic                 out_valid,
    input  wire logic            out_ready,
    output logic [31:0]          out_data,
    output logic                 out_inexact
);

    localparam int              c_idx_w    = $clog2(IN_W);
    localparam int              c_frac_w   = IN_W - 1;
    localparam int              c_ext_w    = IN_W + 24;
    localparam logic [FP32_EXP_W-1:0] c_exp_base = FP32_EXP_W'(FP32_BIAS - FRAC_BITS);

    // ------------------------------------------------------------------
    // Stage occupancy and load enables
    // ------------------------------------------------------------------
    logic r_s1_valid, r_s2_valid, r_s3_valid;
    logic w_load1, w_load2, w_load3;

    assign w_load3   = !r_s3_valid || out_ready;
    assign w_load2   = !r_s2_valid || w_load3;
    assign w_load1   = !r_s1_valid || w_load2;
    assign in_ready  = w_load1;
    assign out_valid = r_s3_valid;

    // ------------------------------------------------------------------
    // S1: sign / magnitude. The most-negative input maps to 2^(IN_W-1),
    // which is representable as an unsigned IN_W-bit magnitude.
    // ------------------------------------------------------------------
    logic            r_s1_sign;
    logic [IN_W-1:0] r_s1_mag;
    logic [IN_W-1:0] w_s1_mag;

    assign w_s1_mag = in_data[IN_W-1] ? -in_data : in_data;

    // ------------------------------------------------------------------
    // S2: leading-one position and normalisation. Only the bits below the
    // implicit leading one are kept.
    // ------------------------------------------------------------------
    logic [c_idx_w-1:0]  w_lead_idx;
    logic                w_lead_valid;
    logic [c_idx_w-1:0]  w_shamt;
    logic [c_frac_w-1:0] w_frac;

    ahfp_lzd_n #(
        .W     (IN_W),
        .IDX_W (c_idx_w)
    ) u_lzd (
        .i_data  (r_s1_mag),
        .o_idx   (w_lead_idx),
        .o_valid (w_lead_valid)
    );

    assign w_shamt = c_idx_w'(IN_W - 1) - w_lead_idx;
    assign w_frac  = c_frac_w'(r_s1_mag << w_shamt);

    logic                r_s2_sign;
    logic                r_s2_zero;
    logic [c_idx_w-1:0]  r_s2_p;
    logic [c_frac_w-1:0] r_s2_frac;

    // ------------------------------------------------------------------
    // S3: pack and round. The fraction is padded below so narrow inputs
    // still yield a full 23-bit mantissa plus guard position.
    // ------------------------------------------------------------------
    logic [c_ext_w-1:0]    w_ext;
    logic [FP32_MAN_W-1:0] w_man;
    logic                  w_guard;
    logic                  w_sticky;
    logic                  w_round_up;
    logic [FP32_MAN_W:0]   w_man_sum;
    logic [FP32_EXP_W-1:0] w_exp;
    fp32_t                 w_res;
    logic                  w_inexact;

    assign w_ext    = {r_s2_frac, 25'd0};
    assign w_man    = w_ext[c_ext_w-1 -: FP32_MAN_W];
    assign w_guard  = w_ext[c_ext_w-1-FP32_MAN_W];
    assign w_sticky = |w_ext[c_ext_w-2-FP32_MAN_W:0];
    assign w_exp    = c_exp_base + FP32_EXP_W'(r_s2_p);

`ifdef AHFP_F2F_ROUND_NEAREST_EN
    assign w_round_up = w_guard & (w_sticky | w_man[0]);
`else
    assign w_round_up = 1'b0;
`endif

    // A carry out of the mantissa leaves it all-zero and bumps the exponent.
    assign w_man_sum = {1'b0, w_man} + (FP32_MAN_W + 1)'(w_round_up);

    always_comb begin
        w_res     = FP32_POS_ZERO;
        w_inexact = 1'b0;
        if (!r_s2_zero) begin
            w_res.sign = r_s2_sign;
            w_res.exp  = w_exp + FP32_EXP_W'(w_man_sum[FP32_MAN_W]);
            w_res.man  = w_man_sum[FP32_MAN_W-1:0];
            w_inexact  = w_guard | w_sticky;
        end
    end

    fp32_t r_out;
    logic  r_out_inexact;

    assign out_data    = r_out;
    assign out_inexact = r_out_inexact;

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid    <= 1'b0;
            r_s2_valid    <= 1'b0;
            r_s3_valid    <= 1'b0;
            r_s1_sign     <= 1'b0;
            r_s1_mag      <= '0;
            r_s2_sign     <= 1'b0;
            r_s2_zero     <= 1'b1;
            r_s2_p        <= '0;
            r_s2_frac     <= '0;
            r_out         <= FP32_POS_ZERO;
            r_out_inexact <= 1'b0;
        end else begin
            if (w_load1) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_sign <= in_data[IN_W-1];
                    r_s1_mag  <= w_s1_mag;
                end
            end
            if (w_load2) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_sign <= r_s1_sign;
                    r_s2_zero <= !w_lead_valid;
                    r_s2_p    <= w_lead_idx;
                    r_s2_frac <= w_frac;
                end
            end
            if (w_load3) begin
                r_s3_valid <= r_s2_valid;
                if (r_s2_valid) begin
                    r_out         <= w_res;
                    r_out_inexact <= w_inexact;
                end
            end
        end
    end

endmodule
`default_nettype wire
